// File: rtl/present_pkg.sv
// Shared constants and helpers for the PRESENT-80 datapath.
// PRESENT_SP_INV_EN enables the inverse (decryption) path in the S/P layer.
package present_pkg;

    localparam int STATE_W = 64;
    localparam int NIB_W   = 4;

    localparam logic [3:0] SBOX_TBL [0:15] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] SBOX_INV_TBL [0:15] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    // Destination bit of source bit i in the PRESENT bit permutation.
    function automatic int unsigned p_index(input int unsigned i);
        int unsigned r;
        if (i == 32'd63) begin
            r = 32'd63;
        end else begin
            r = (32'd16 * i) % 32'd63;
        end
        return r;
    endfunction

endpackage

// File: rtl/present_sp_layer_if.sv
// Input/output bundle of the PRESENT S/P layer.
// The inv select only exists when PRESENT_SP_INV_EN is defined.
interface present_sp_layer_if;
    import present_pkg::*;

    logic               in_valid;
    logic [STATE_W-1:0] in_data;
`ifdef PRESENT_SP_INV_EN
    logic               inv;
`endif
    logic               out_valid;
    logic [STATE_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
`ifdef PRESENT_SP_INV_EN
        output inv,
`endif
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
`ifdef PRESENT_SP_INV_EN
        input  inv,
`endif
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/present_sbox4.sv
// Combinational 4-bit PRESENT S-box with inverse select.
// Shared by the round S/P layer and the key schedule.
module present_sbox4
    import present_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    input  logic             inv,
    output logic [NIB_W-1:0] sub
);

    // Table lookup, forward or inverse.
    always_comb begin
        sub = 4'h0;
        if (inv) begin
            sub = SBOX_INV_TBL[nib];
        end else begin
            sub = SBOX_TBL[nib];
        end
    end

endmodule

// File: rtl/present_sp_layer.sv
// Registered PRESENT-80 S-layer + pLayer, one result per cycle, 1-cycle latency.
// Defining PRESENT_SP_INV_EN adds the inverse path (pLayer_inv then sLayer_inv).
module present_sp_layer
    import present_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    present_sp_layer_if.slave  bus
);

    logic               inv_s;
    logic [STATE_W-1:0] pinv_s;
    logic [STATE_W-1:0] sbox_in_s;
    logic [STATE_W-1:0] sbox_out_s;
    logic [STATE_W-1:0] perm_s;
    logic [STATE_W-1:0] result_s;
    logic               out_valid_r;
    logic [STATE_W-1:0] out_data_r;

`ifdef PRESENT_SP_INV_EN
    assign inv_s = bus.inv;
`else
    assign inv_s = 1'b0;
`endif

    // Inverse permutation: output bit i takes input bit P(i).
    always_comb begin
        pinv_s = '0;
        for (int i = 0; i < STATE_W; i++) begin
            pinv_s[i] = bus.in_data[p_index(i)];
        end
    end

    // The inverse path permutes before substitution, the forward path after.
    always_comb begin
        sbox_in_s = bus.in_data;
        if (inv_s) begin
            sbox_in_s = pinv_s;
        end else begin
            sbox_in_s = bus.in_data;
        end
    end

    for (genvar n = 0; n < STATE_W / NIB_W; n++) begin : g_sbox
        present_sbox4 u_sbox (
            .nib (sbox_in_s[n*NIB_W +: NIB_W]),
            .inv (inv_s),
            .sub (sbox_out_s[n*NIB_W +: NIB_W])
        );
    end

    // Forward permutation: intermediate bit i moves to bit P(i).
    always_comb begin
        perm_s = '0;
        for (int i = 0; i < STATE_W; i++) begin
            perm_s[p_index(i)] = sbox_out_s[i];
        end
    end

    // Select the finished result for the active direction.
    always_comb begin
        result_s = perm_s;
        if (inv_s) begin
            result_s = sbox_out_s;
        end else begin
            result_s = perm_s;
        end
    end

    // Output register; data holds when no new input arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 64'h0;
        end else if (bus.in_valid) begin
            out_valid_r <= 1'b1;
            out_data_r  <= result_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_present_sp_layer.sv
// Scoreboard testbench for present_sp_layer; inverse checks need PRESENT_SP_INV_EN.
module tb_present_sp_layer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inv_last = 1'b0;

    present_sp_layer_if bus();

    present_sp_layer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    localparam logic [3:0] S_REF [0:15] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    // Reference forward round: substitute, then bit 4k+j goes to 16j+k.
    function automatic logic [63:0] fwd_model(input logic [63:0] x);
        logic [63:0] s;
        logic [63:0] y;
        for (int k = 0; k < 16; k++) s[4*k +: 4] = S_REF[x[4*k +: 4]];
        y = '0;
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 4; j++)
                y[16*j + k] = s[4*k + j];
        return y;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of input; queue the expected result when it will be accepted.
    task automatic send(input logic v, input logic [63:0] d, input logic i_inv, input logic [63:0] e);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_data  = d;
`ifdef PRESENT_SP_INV_EN
        bus.inv      = i_inv;
`endif
        inv_last = i_inv;
        if (v && rst_n) exp_q.push_back(e);
    endtask

    // Monitor: every valid output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h expected no output", bus.out_data);
            end else begin
                check("scoreboard", bus.out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [63:0] x;

        bus.in_valid = 1'b1;
        bus.in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef PRESENT_SP_INV_EN
        bus.inv      = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", {63'h0, bus.out_valid}, 64'h0);
        check("reset_data", bus.out_data, 64'h0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;

        // Directed vectors, one at a time.
        send(1'b1, 64'h0, 1'b0, 64'hFFFF_FFFF_0000_0000);
        send(1'b0, 64'h0, 1'b0, 64'h0);
        send(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0000_0000_FFFF_0000);
        send(1'b0, 64'h0, 1'b0, 64'h0);
        send(1'b1, 64'h0000_0000_0000_0005, 1'b0, 64'hFFFE_FFFE_0000_0000);
        send(1'b0, 64'h0, 1'b0, 64'h0);

        // Back-to-back stream, then hold.
        send(1'b1, 64'h0, 1'b0, 64'hFFFF_FFFF_0000_0000);
        send(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0000_0000_FFFF_0000);
        send(1'b1, 64'h0000_0000_0000_0005, 1'b0, 64'hFFFE_FFFE_0000_0000);
        send(1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0);
        @(posedge clk);
        #1;
        check("hold_valid", {63'h0, bus.out_valid}, 64'h0);
        check("hold_data", bus.out_data, 64'hFFFE_FFFE_0000_0000);

        // Known-answer and random forward vectors against the reference model.
        send(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, fwd_model(64'h0123_4567_89AB_CDEF));
        send(1'b1, 64'hFEDC_BA98_7654_3210, 1'b0, fwd_model(64'hFEDC_BA98_7654_3210));
        for (int r = 0; r < 8; r++) begin
            x = {$urandom(), $urandom()};
            send(1'b1, x, 1'b0, fwd_model(x));
        end

        // Reset in mid-stream: the input sampled with rst_n=0 is dropped.
        send(1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, fwd_model(64'hA5A5_5A5A_0F0F_F0F0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.in_data = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk);
        #1;
        check("midreset_valid", {63'h0, bus.out_valid}, 64'h0);
        check("midreset_data", bus.out_data, 64'h0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        send(1'b1, 64'h0000_0000_0000_0005, 1'b0, 64'hFFFE_FFFE_0000_0000);

`ifdef PRESENT_SP_INV_EN
        send(1'b1, 64'hFFFF_FFFF_0000_0000, 1'b1, 64'h0);
        send(1'b1, 64'h0000_0000_FFFF_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int r = 0; r < 6; r++) begin
            x = {$urandom(), $urandom()};
            send(1'b1, fwd_model(x), 1'b1, x);
        end
        send(1'b1, 64'h0, 1'b0, 64'hFFFF_FFFF_0000_0000);
`endif

        send(1'b0, 64'h0, 1'b0, 64'h0);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
